// File: rtl/hist_pkg.sv
// Shared constants and state type for the histogram builder/renderer.
package hist_pkg;

  localparam int NBINS  = 256;
  localparam int BIN_AW = 8;

  localparam logic [7:0] PIX_WHITE = 8'd255;
  localparam logic [7:0] PIX_BLACK = 8'd0;

  typedef enum logic [1:0] {
    INIT,
    ACCUM,
    CLEAR
  } histState_t;

endpackage

// File: rtl/hist_bank.sv
// One histogram bin bank: 256-entry simple dual-port RAM with a registered read.
// A read and a write to the same address in one cycle return the old contents.
module hist_bank
  import hist_pkg::*;
#(
  parameter int COUNT_W = 20
) (
  input  logic               iClk,
  input  logic               wrEn,
  input  logic [BIN_AW-1:0]  wrAddr,
  input  logic [COUNT_W-1:0] wrData,
  input  logic [BIN_AW-1:0]  rdAddr,
  output logic [COUNT_W-1:0] rdData
);

  logic [COUNT_W-1:0] mem [NBINS];

  always_ff @(posedge iClk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/hist_render.sv
// Ping-pong 256-bin gray histogram: one bank accumulates the current frame while
// the other, completed last frame, is drawn as vertical bars on the live raster.
module hist_render
  import hist_pkg::*;
#(
  parameter int IMG_H       = 480,
  parameter int COUNT_W     = 20,
  parameter int SCALE_SHIFT = 8,
  parameter int BIN_SHIFT   = 1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iFval,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic [7:0]  iGray,
  input  logic        iGray_Valid,
  input  logic [7:0]  iThresholdLevel,
  output logic [7:0]  oHist,
  output logic        oHist_Valid,
  output logic        oHist_Red,
  output logic        oBusy,
  output logic        oOverrun
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  histState_t        state, stateNext;
  logic [BIN_AW-1:0] clrAddr;
  logic              accSel;
  logic              fvalD;
  logic [7:0]        threshold;

  logic fvalRise, fvalFall, busy, pixCount;
  assign fvalRise = iFval & ~fvalD;
  assign fvalFall = ~iFval & fvalD;
  assign busy     = (state != ACCUM);
  assign pixCount = iGray_Valid & ~busy;
  assign oBusy    = busy;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= INIT;
      clrAddr   <= '0;
      accSel    <= 1'b0;
      fvalD     <= 1'b0;
      threshold <= '0;
    end else begin
      state <= stateNext;
      fvalD <= iFval;
      if (fvalRise) threshold <= iThresholdLevel;
      // Wraps back to 0 exactly when the clear sweep hands over to ACCUM.
      if (busy) clrAddr <= clrAddr + 8'd1;
      if (state == ACCUM && fvalFall) accSel <= ~accSel;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      INIT:    if (clrAddr == 8'hFF) stateNext = ACCUM;
      ACCUM:   if (fvalFall) stateNext = CLEAR;
      CLEAR:   if (clrAddr == 8'hFF) stateNext = ACCUM;
      default: stateNext = INIT;
    endcase
  end

  // Accumulate read-modify-write pipeline.
  logic               acV, acSel, fwdHit;
  logic [BIN_AW-1:0]  acAddr;
  logic [COUNT_W-1:0] fwdData, rdA, rdB, acRd, acSrc, acIncr;

  assign acRd   = acSel ? rdB : rdA;
  assign acSrc  = fwdHit ? fwdData : acRd;
  assign acIncr = (acSrc == COUNT_MAX) ? acSrc : acSrc + COUNT_W'(1);

  // The RAM returns stale data when the previous pixel writes the bin we read,
  // so that case takes the freshly computed count instead.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      acV     <= 1'b0;
      acSel   <= 1'b0;
      acAddr  <= '0;
      fwdHit  <= 1'b0;
      fwdData <= '0;
    end else begin
      acV     <= pixCount;
      acSel   <= accSel;
      acAddr  <= iGray;
      fwdHit  <= pixCount & acV & (iGray == acAddr) & (accSel == acSel);
      fwdData <= acIncr;
    end
  end

  logic              clearA, clearB, wrEnA, wrEnB;
  logic [BIN_AW-1:0] wrAddrA, wrAddrB, rdAddrA, rdAddrB, renderBin;
  logic [COUNT_W-1:0] wrDataA, wrDataB;

  assign renderBin = iX_Cont[BIN_SHIFT +: BIN_AW];
  assign clearA    = (state == INIT) | ((state == CLEAR) & ~accSel);
  assign clearB    = (state == INIT) | ((state == CLEAR) & accSel);
  assign wrEnA     = clearA | (acV & ~acSel);
  assign wrEnB     = clearB | (acV & acSel);
  assign wrAddrA   = clearA ? clrAddr : acAddr;
  assign wrAddrB   = clearB ? clrAddr : acAddr;
  assign wrDataA   = clearA ? '0 : acIncr;
  assign wrDataB   = clearB ? '0 : acIncr;
  assign rdAddrA   = accSel ? renderBin : iGray;
  assign rdAddrB   = accSel ? iGray : renderBin;

  hist_bank #(.COUNT_W(COUNT_W)) bankA (
    .iClk(iClk), .wrEn(wrEnA), .wrAddr(wrAddrA), .wrData(wrDataA),
    .rdAddr(rdAddrA), .rdData(rdA)
  );

  hist_bank #(.COUNT_W(COUNT_W)) bankB (
    .iClk(iClk), .wrEn(wrEnB), .wrAddr(wrAddrB), .wrData(wrDataB),
    .rdAddr(rdAddrB), .rdData(rdB)
  );

  // Render: stage 1 captures geometry alongside the RAM read, stage 2 compares.
  logic              rnV, rnSel, rnBinOver, rnYOver;
  logic [BIN_AW-1:0] rnBin;
  logic [15:0]       rnRow;
  logic [COUNT_W-1:0] rnData;
  logic [31:0]       rnScaled, rnHeight;
  logic              barOn;

  assign rnData   = rnSel ? rdB : rdA;
  assign rnScaled = 32'(rnData) >> SCALE_SHIFT;
  assign rnHeight = (rnScaled > 32'(IMG_H)) ? 32'(IMG_H) : rnScaled;
  assign barOn    = ~rnBinOver & ~rnYOver & (rnHeight > {16'd0, rnRow});

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rnV         <= 1'b0;
      rnSel       <= 1'b0;
      rnBinOver   <= 1'b0;
      rnYOver     <= 1'b0;
      rnBin       <= '0;
      rnRow       <= '0;
      oHist       <= PIX_BLACK;
      oHist_Valid <= 1'b0;
      oHist_Red   <= 1'b0;
      oOverrun    <= 1'b0;
    end else begin
      rnV         <= iGray_Valid;
      rnSel       <= ~accSel;
      rnBinOver   <= (iX_Cont >> (BIN_AW + BIN_SHIFT)) != 16'd0;
      rnYOver     <= iY_Cont >= 16'(IMG_H);
      rnBin       <= renderBin;
      rnRow       <= 16'(IMG_H - 1) - iY_Cont;
      oHist       <= barOn ? PIX_WHITE : PIX_BLACK;
      oHist_Valid <= rnV;
      oHist_Red   <= ~rnBinOver & (rnBin == threshold);
      oOverrun    <= iGray_Valid & busy;
    end
  end

endmodule

// File: tb/tb_hist_render.sv
// Bench for hist_render: two instances (20-bit and 4-bit counters) checked every
// cycle against a frame-level histogram model, plus hand-computed bar probes.
module tb_hist_render;

  localparam int IMG_H = 480;
  localparam int SCALE = 0;
  localparam int CW_A  = 20;
  localparam int CW_B  = 4;

  logic        iClk, iRst, iFval, iGray_Valid;
  logic [15:0] iX_Cont, iY_Cont;
  logic [7:0]  iGray, iThresholdLevel;
  logic [7:0]  oHistA, oHistB;
  logic        oValidA, oValidB, oRedA, oRedB, oBusyA, oBusyB, oOverA, oOverB;

  hist_render #(.IMG_H(IMG_H), .COUNT_W(CW_A), .SCALE_SHIFT(SCALE), .BIN_SHIFT(1)) dutA (
    .iClk(iClk), .iRst(iRst), .iFval(iFval), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iGray(iGray), .iGray_Valid(iGray_Valid), .iThresholdLevel(iThresholdLevel),
    .oHist(oHistA), .oHist_Valid(oValidA), .oHist_Red(oRedA), .oBusy(oBusyA),
    .oOverrun(oOverA)
  );

  hist_render #(.IMG_H(IMG_H), .COUNT_W(CW_B), .SCALE_SHIFT(SCALE), .BIN_SHIFT(1)) dutB (
    .iClk(iClk), .iRst(iRst), .iFval(iFval), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iGray(iGray), .iGray_Valid(iGray_Valid), .iThresholdLevel(iThresholdLevel),
    .oHist(oHistB), .oHist_Valid(oValidB), .oHist_Red(oRedB), .oBusy(oBusyB),
    .oOverrun(oOverB)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int passCount = 0;
  int checkCount = 0;
  bit checkOn = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Frame-level model: true bin counts, a busy window after reset or a frame end.
  int unsigned curCnt[256];
  int unsigned shownCnt[256];
  int  busyLeft;
  bit  prevFval;
  int  thr;
  bit  s1V, s1Red, expV, expRed, expOver, expBusy;
  int  s1HistA, s1HistB, expHistA, expHistB;

  function automatic int modelPixel(input int unsigned cnt, input int cw, input int bin, input int y);
    int unsigned h;
    int unsigned maxC;
    maxC = (32'd1 << cw) - 1;
    if (bin > 255 || y >= IMG_H) return 0;
    h = (cnt > maxC) ? maxC : cnt;
    h = h >> SCALE;
    if (h > IMG_H) h = IMG_H;
    return (int'(h) > IMG_H - 1 - y) ? 255 : 0;
  endfunction

  always @(posedge iClk) begin
    int bin;
    if (iRst) begin
      foreach (curCnt[i]) begin curCnt[i] = 0; shownCnt[i] = 0; end
      busyLeft = 256; prevFval = 0; thr = 0;
      s1V = 0; s1Red = 0; s1HistA = 0; s1HistB = 0;
      expV = 0; expRed = 0; expHistA = 0; expHistB = 0; expOver = 0; expBusy = 1;
    end else begin
      if (iFval && !prevFval) thr = int'(iThresholdLevel);
      expV = s1V; expRed = s1Red; expHistA = s1HistA; expHistB = s1HistB;
      bin = int'(iX_Cont) >> 1;
      s1V = iGray_Valid;
      s1HistA = modelPixel(shownCnt[bin % 256], CW_A, bin, int'(iY_Cont));
      s1HistB = modelPixel(shownCnt[bin % 256], CW_B, bin, int'(iY_Cont));
      s1Red = (bin <= 255) && (bin == thr);
      expOver = iGray_Valid && (busyLeft > 0);
      if (busyLeft > 0) busyLeft--;
      else begin
        if (iGray_Valid) curCnt[iGray]++;
        if (!iFval && prevFval) begin
          shownCnt = curCnt;
          foreach (curCnt[i]) curCnt[i] = 0;
          busyLeft = 256;
        end
      end
      expBusy = (busyLeft > 0);
      prevFval = iFval;
    end
  end

  always @(negedge iClk) begin
    if (checkOn) begin
      checkOutput("busyA", oBusyA, expBusy);
      checkOutput("busyB", oBusyB, expBusy);
      checkOutput("overrunA", oOverA, expOver);
      checkOutput("overrunB", oOverB, expOver);
      checkOutput("validA", oValidA, expV);
      checkOutput("validB", oValidB, expV);
      if (expV) begin
        checkOutput("histA", oHistA, expHistA);
        checkOutput("histB", oHistB, expHistB);
        checkOutput("redA", oRedA, expRed);
        checkOutput("redB", oRedB, expRed);
      end
    end
  end

  task automatic applyStimulus(input logic fv, input int x, input int y, input int g, input logic v);
    iFval = fv;
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    iGray = 8'(g);
    iGray_Valid = v;
    @(negedge iClk);
  endtask

  task automatic renderProbe(input string name, input int x, input int y,
                             input int eA, input int eB, input int eRed);
    applyStimulus(1'b1, x, y, 200, 1'b1);
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    checkOutput({name, "/histA"}, oHistA, eA);
    checkOutput({name, "/histB"}, oHistB, eB);
    checkOutput({name, "/red"}, oRedA, eRed);
  endtask

  initial begin
    iRst = 1'b1; iFval = 1'b0; iX_Cont = '0; iY_Cont = '0;
    iGray = '0; iGray_Valid = 1'b0; iThresholdLevel = '0;
    @(negedge iClk);
    @(negedge iClk);
    checkOn = 1;
    checkOutput("resetBusy", oBusyA, 1);
    checkOutput("resetValid", oValidA, 0);
    checkOutput("resetHist", oHistA, 0);
    iRst = 1'b0;

    // INIT sweep: off-screen pixels are dropped with an overrun pulse.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 600, 0, 5, 1'b1);
    for (int i = 10; i < 255; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("initBusyLast", oBusyA, 1);
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("initDone", oBusyA, 0);
    repeat (4) applyStimulus(1'b0, 0, 0, 0, 1'b0);

    // Frame 1: 512 back-to-back gray 10 pixels, renders black.
    iThresholdLevel = 8'd100;
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 512; i++) applyStimulus(1'b1, i, (i * 7) % 500, 10, 1'b1);
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    repeat (300) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("modelBin10", int'(shownCnt[10]), 512);

    // Frame 2: gray 3,3,4,3 pattern; threshold input changes mid-frame.
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) iThresholdLevel = 8'd50;
      applyStimulus(1'b1, i % 530, (i * 37) % 490, (i % 4 == 2) ? 4 : 3, 1'b1);
    end
    renderProbe("bin10Top", 20, 0, 255, 0, 0);
    renderProbe("thrCol", 200, 300, 0, 0, 1);
    renderProbe("thrNext", 202, 300, 0, 0, 0);
    renderProbe("bin11Bottom", 22, 479, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("modelBin3", int'(shownCnt[3]), 750);
    checkOutput("modelBin4", int'(shownCnt[4]), 250);

    // Frame 3 starts 100 cycles into the clear: 56 dropped gray-7 pixels.
    repeat (99) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 56; i++) applyStimulus(1'b1, i, 470, 7, 1'b1);
    repeat (110) applyStimulus(1'b1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, i * 3, 100, 0, 1'b1);
    renderProbe("bin3Top", 6, 0, 255, 0, 0);
    renderProbe("bin4Edge", 8, 230, 255, 0, 0);
    renderProbe("bin4Above", 8, 229, 0, 0, 0);
    renderProbe("bin4Low", 8, 465, 255, 255, 0);
    renderProbe("yBeyond", 8, 480, 0, 0, 0);
    renderProbe("xBeyond", 520, 479, 0, 0, 0);
    renderProbe("thr50", 100, 0, 0, 0, 1);
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("modelBin7", int'(shownCnt[7]), 0);
    checkOutput("modelBin0", int'(shownCnt[0]), 20);
    repeat (300) applyStimulus(1'b0, 0, 0, 0, 1'b0);

    // Frame 4: dropped bin stays black, bin 0 saturates in the 4-bit instance.
    iThresholdLevel = 8'd7;
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    renderProbe("droppedBin7", 14, 479, 0, 0, 1);
    renderProbe("bin0A", 0, 460, 255, 0, 0);
    renderProbe("bin0AEdge", 0, 459, 0, 0, 0);
    renderProbe("bin0Sat", 0, 465, 255, 255, 0);
    renderProbe("bin0SatEdge", 0, 464, 255, 0, 0);

    // Reset in the middle of a pixel burst.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, i, 10, 9, 1'b1);
    iRst = 1'b1;
    applyStimulus(1'b1, 5, 10, 9, 1'b1);
    iRst = 1'b0;
    checkOutput("midResetBusy", oBusyA, 1);
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    checkOutput("midResetValid", oValidA, 0);
    repeat (260) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("midResetDone", oBusyA, 0);

    checkOn = 0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
